fetch_unit: RTL and testbench
=============================

# fetch_unit

Parametrised instruction-fetch stage for the next-generation RISC-V core. It replaces the bare PC register and `PC + 4`/branch adder with several capabilities:
- a variable-latency, handshaked instruction-memory interface with multiple outstanding requests;
- an in-order prefetch buffer;
- back-pressure from decode;
- a single redirect port for branches, jumps and traps.

It sits between the instruction memory and the decode stage.

## Interface
Parameters:
- `XLEN`, 32: address/PC width.
- `RESET_VECTOR`, `'0`: first fetch address after reset; bits [1:0] must be 0.
- `DEPTH`, 4: prefetch-buffer entries, power of two, ≥ 2. It also bounds outstanding requests.

Ports:
- `CLK` in 1: single clock, rising edge.
- `RESET` in 1: asynchronous, active-high reset.
- `IMEM_REQ` out 1: fetch request valid.
- `IMEM_ADDR` out XLEN: fetch address, word aligned.
- `IMEM_GNT` in 1: request accepted when `IMEM_REQ && IMEM_GNT`.
- `IMEM_RVALID` in 1: response valid. Responses arrive in request order, at least 1 cycle after grant.
- `IMEM_RDATA` in 32: response instruction word.
- `INSTR_VALID` out 1: decode-side instruction valid.
- `INSTR` out 32: instruction word.
- `INSTR_PC` out XLEN: PC of `INSTR`.
- `INSTR_READY` in 1: decode accepts; a pop occurs on `INSTR_VALID && INSTR_READY`.
- `REDIRECT` in 1: discard the stream and restart at `REDIRECT_PC`.
- `REDIRECT_PC` in XLEN: new fetch address. Bits [1:0] are forced to 0.

## Operation
- Internal state:
  - `fetch_pc`;
  - buffer with three pointers: alloc (advances on grant, writes PC), fill (advances on accepted response, writes data, sets filled), read (advances on pop);
  - `alloc_count`: entries allocated and not popped;
  - `discard_cnt`: in-flight responses to drop.
- `IMEM_REQ = (alloc_count < DEPTH)`, using registered state only.
- `IMEM_ADDR = fetch_pc`.
- On grant: allocate an entry holding `fetch_pc`, then `fetch_pc += 4`. XLEN-bit wrap at the top of the address space is allowed.
- While `IMEM_REQ && !IMEM_GNT`: `IMEM_ADDR` is held stable.
- On `IMEM_RVALID`:
  - if `discard_cnt > 0`: decrement it and drop the data;
  - otherwise: write data to the fill entry and advance fill.
- Output: `INSTR_VALID` = head entry allocated and filled. `INSTR` and `INSTR_PC` come from the head entry and are stable until popped.
- `REDIRECT` (priority over everything):
  - A pop in the same cycle is honoured.
  - `fetch_pc <= {REDIRECT_PC[XLEN-1:2], 2'b00}`.
  - All entries are invalidated.
  - `discard_cnt <=` allocated-but-unfilled requests, plus any grant in the redirect cycle, minus any response accepted in the redirect cycle.
- Simultaneous grant, response and pop in one cycle: each is applied; `alloc_count` changes by +1 − 1 = 0.
- A pop frees its credit the next cycle. There is no same-cycle full bypass.

## Timing
- During `RESET`:
  - `IMEM_REQ=0`, `INSTR_VALID=0`, `IMEM_ADDR=RESET_VECTOR`, `INSTR=0`, `INSTR_PC=0`;
  - all counters and pointers are 0.
  - Assertion mid-operation clears everything asynchronously. The instruction memory shares `RESET`, so no stale responses follow.
- First cycle after release: `IMEM_REQ=1`, `IMEM_ADDR=RESET_VECTOR`.
- Latency: grant at cycle t, `RVALID` at t+1, `INSTR_VALID` at t+2.
- Throughput: 1 instruction/cycle when memory latency L satisfies `DEPTH ≥ L+1` and `INSTR_READY=1`.
- Redirect at cycle t:
  - `INSTR_VALID=0` and `IMEM_ADDR=REDIRECT_PC` at t+1;
  - first redirected instruction appears at t+3 at the earliest.
- Full (`alloc_count==DEPTH`): `IMEM_REQ=0`.
- Empty or unfilled head: `INSTR_VALID=0`.

## Structure
- `fetch_pkg`:
  - `fetch_entry_t` struct: `pc[XLEN]`, `instr[32]`, `filled`;
  - `INSTR_BYTES=4`;
  - `NOP_INSTR=32'h00000013`, used for the `INSTR` idle value in simulation checks.
- Sub-module `fetch_queue`: the three-pointer buffer with alloc, fill and pop ports and a flush input. `fetch_unit` holds `fetch_pc`, the request logic and `discard_cnt`.

## Test plan
1. **Reset, streaming.** `RESET_VECTOR=0`, `GNT=1`, L=1 memory, `READY=1`. Expect:
   - `IMEM_ADDR` 0x0, 0x4, 0x8, … on consecutive cycles;
   - `INSTR_VALID` from the 3rd cycle after release;
   - `INSTR_PC` increments by 4 every cycle.
2. **Back-pressure.** `DEPTH=4`, `READY=0`. Expect:
   - exactly 4 grants (0x0–0xC), then `IMEM_REQ=0`;
   - `INSTR_PC` held at 0x0.
   Then raise `READY`: expect pops 0x0, 0x4, 0x8, 0xC with no gaps, and a request for 0x10 the cycle after the first pop.
3. **Grant stall.** Hold `GNT=0` for 3 cycles at 0x8. Expect `IMEM_ADDR=0x8` and `IMEM_REQ=1` held stable; no 0xC request until grant.
4. **Redirect with in-flight requests.** L=3, 2 requests outstanding; `REDIRECT=1`, `REDIRECT_PC=0x100`. Expect:
   - both old responses dropped;
   - next `INSTR_PC=0x100` carrying the 0x100 response data;
   - never PC 0x8 or 0xC.
5. **Misaligned redirect and wrap.** `REDIRECT_PC=0x203`: expect `IMEM_ADDR=0x200`. Redirect to 0xFFFFFFFC: expect the next address is 0x0.
6. **Mid-stream reset.** Assert `RESET` with the buffer full. Expect:
   - `INSTR_VALID` and `IMEM_REQ` go 0 without a clock edge;
   - after release, `IMEM_ADDR=RESET_VECTOR` and no pre-reset instruction is delivered.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage
package fetch_pkg;
  localparam int MAX_XLEN = 64;
  localparam int INSTR_BYTES = 4;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  typedef struct packed {
    logic [MAX_XLEN-1:0] pc;
    logic [31:0] instr;
    logic filled;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: in-order prefetch buffer with alloc, fill and read pointers
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic alloc,
  input  logic [XLEN-1:0] alloc_pc,
  input  logic fill,
  input  logic [31:0] fill_data,
  input  logic pop,
  output logic [$clog2(DEPTH):0] count,
  output logic [$clog2(DEPTH):0] unfilled,
  output logic head_valid,
  output logic [31:0] head_instr,
  output logic [XLEN-1:0] head_pc
);
  localparam int AW = $clog2(DEPTH);
  fetch_entry_t mem [DEPTH];
  fetch_entry_t head;
  logic [AW:0] a_ptr, f_ptr, r_ptr;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_ptr <= '0;
      f_ptr <= '0;
      r_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      a_ptr <= '0;
      f_ptr <= '0;
      r_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i].filled <= 1'b0;
    end else begin
      if (alloc) begin
        mem[a_ptr[AW-1:0]].pc <= MAX_XLEN'(alloc_pc);
        mem[a_ptr[AW-1:0]].filled <= 1'b0;
        a_ptr <= a_ptr + 1'b1;
      end
      // responses only ever land on entries allocated in an earlier cycle
      if (fill) begin
        mem[f_ptr[AW-1:0]].instr <= fill_data;
        mem[f_ptr[AW-1:0]].filled <= 1'b1;
        f_ptr <= f_ptr + 1'b1;
      end
      if (pop) r_ptr <= r_ptr + 1'b1;
    end
  end
  assign head = mem[r_ptr[AW-1:0]];
  assign count = a_ptr - r_ptr;
  assign unfilled = a_ptr - f_ptr;
  assign head_valid = count != '0 && head.filled;
  assign head_instr = head.instr;
  assign head_pc = XLEN'(head.pc);
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC sequencing, handshaked imem requests and redirect discard tracking
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int DEPTH = 4
) (
  input  logic CLK,
  input  logic RESET,
  output logic IMEM_REQ,
  output logic [XLEN-1:0] IMEM_ADDR,
  input  logic IMEM_GNT,
  input  logic IMEM_RVALID,
  input  logic [31:0] IMEM_RDATA,
  output logic INSTR_VALID,
  output logic [31:0] INSTR,
  output logic [XLEN-1:0] INSTR_PC,
  input  logic INSTR_READY,
  input  logic REDIRECT,
  input  logic [XLEN-1:0] REDIRECT_PC
);
  localparam int AW = $clog2(DEPTH);
  // repeated redirects can stack stale responses beyond DEPTH, so give headroom
  localparam int DW = AW + 4;
  logic [XLEN-1:0] fetch_pc;
  logic [DW-1:0] discard_cnt;
  logic [AW:0] count, unfilled;
  logic gnt, drop, fill, pop;
  assign IMEM_REQ = !RESET && count != (AW+1)'(DEPTH);
  assign IMEM_ADDR = fetch_pc;
  assign gnt = IMEM_REQ && IMEM_GNT;
  assign drop = IMEM_RVALID && discard_cnt != '0;
  assign fill = IMEM_RVALID && !drop;
  assign pop = INSTR_VALID && INSTR_READY;
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      fetch_pc <= RESET_VECTOR;
      discard_cnt <= '0;
    end else if (REDIRECT) begin
      fetch_pc <= REDIRECT_PC & ~XLEN'(3);
      discard_cnt <= discard_cnt + DW'(unfilled) + DW'(gnt) - DW'(IMEM_RVALID);
    end else begin
      if (gnt) fetch_pc <= fetch_pc + XLEN'(INSTR_BYTES);
      if (drop) discard_cnt <= discard_cnt - 1'b1;
    end
  end
  fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) u_queue (
    .clk(CLK),
    .rst(RESET),
    .flush(REDIRECT),
    .alloc(gnt),
    .alloc_pc(fetch_pc),
    .fill(fill),
    .fill_data(IMEM_RDATA),
    .pop(pop),
    .count(count),
    .unfilled(unfilled),
    .head_valid(INSTR_VALID),
    .head_instr(INSTR),
    .head_pc(INSTR_PC)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench with an in-order variable-latency memory model
module tb_fetch_unit;
  logic CLK = 0, RESET = 1;
  logic IMEM_REQ, IMEM_GNT = 1, IMEM_RVALID = 0;
  logic [31:0] IMEM_ADDR, IMEM_RDATA = '0;
  logic INSTR_VALID, INSTR_READY = 1, REDIRECT = 0;
  logic [31:0] INSTR, INSTR_PC, REDIRECT_PC = '0;
  typedef struct {logic [31:0] pc; logic [31:0] d;} exp_t;
  typedef struct {logic [31:0] d; int due;} rsp_t;
  exp_t exp_q[$];
  rsp_t mem_q[$];
  int vectors = 0, errors = 0, cyc = 0, lat = 1, grants;
  fetch_unit #(.XLEN(32), .RESET_VECTOR(32'h0), .DEPTH(4)) dut (
    .CLK(CLK), .RESET(RESET), .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR),
    .IMEM_GNT(IMEM_GNT), .IMEM_RVALID(IMEM_RVALID), .IMEM_RDATA(IMEM_RDATA),
    .INSTR_VALID(INSTR_VALID), .INSTR(INSTR), .INSTR_PC(INSTR_PC),
    .INSTR_READY(INSTR_READY), .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC)
  );
  always #5 CLK = ~CLK;
  function automatic logic [31:0] md(input logic [31:0] a);
    return a ^ 32'hA5A5_0000 ^ {a[7:0], 24'h0};
  endfunction
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge CLK);
    #1;
  endtask
  task automatic do_reset;
    step();
    RESET = 1;
    @(negedge CLK);
    check("rst_req", IMEM_REQ, 0);
    check("rst_valid", INSTR_VALID, 0);
    check("rst_addr", IMEM_ADDR, 0);
    check("rst_instr", INSTR, 0);
    check("rst_pc", INSTR_PC, 0);
    step();
    RESET = 0;
  endtask
  // memory: answers in grant order, lat cycles after the grant
  initial forever begin
    @(posedge CLK);
    cyc++;
    #2;
    if (!RESET && mem_q.size() != 0 && mem_q[0].due <= cyc) begin
      IMEM_RVALID = 1;
      IMEM_RDATA = mem_q[0].d;
      mem_q.delete(0);
    end else IMEM_RVALID = 0;
  end
  // scoreboard: every granted, non-flushed address must be delivered in order
  initial forever begin
    @(negedge CLK);
    if (RESET) begin
      exp_q.delete();
      mem_q.delete();
    end else begin
      if (INSTR_VALID && INSTR_READY) begin
        check("sb_nonempty", 64'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          check("pop_pc", INSTR_PC, exp_q[0].pc);
          check("pop_instr", INSTR, exp_q[0].d);
          exp_q.delete(0);
        end
      end
      if (IMEM_REQ && IMEM_GNT) mem_q.push_back('{d: md(IMEM_ADDR), due: cyc + lat});
      if (REDIRECT) exp_q.delete();
      else if (IMEM_REQ && IMEM_GNT) exp_q.push_back('{pc: IMEM_ADDR, d: md(IMEM_ADDR)});
    end
  end
  initial begin
    do_reset();
    for (int k = 0; k < 7; k++) begin
      @(negedge CLK);
      check("stream_addr", IMEM_ADDR, 64'(4 * k));
      check("stream_valid", INSTR_VALID, 64'(k >= 2));
      if (k >= 2) check("stream_pc", INSTR_PC, 64'(4 * (k - 2)));
      step();
    end
    INSTR_READY = 0;
    do_reset();
    grants = 0;
    repeat (8) begin
      @(negedge CLK);
      if (IMEM_REQ && IMEM_GNT) grants++;
      step();
    end
    @(negedge CLK);
    check("bp_grants", grants, 4);
    check("bp_req_off", IMEM_REQ, 0);
    check("bp_hold_pc", INSTR_PC, 0);
    check("bp_hold_valid", INSTR_VALID, 1);
    step();
    INSTR_READY = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      check("bp_pop_valid", INSTR_VALID, 1);
      check("bp_pop_pc", INSTR_PC, 64'(4 * i));
      if (i == 0) check("bp_still_full", IMEM_REQ, 0);
      if (i == 1) begin
        check("bp_credit_req", IMEM_REQ, 1);
        check("bp_credit_addr", IMEM_ADDR, 32'h10);
      end
      step();
    end
    do_reset();
    step();
    step();
    IMEM_GNT = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("stall_addr", IMEM_ADDR, 32'h8);
      check("stall_req", IMEM_REQ, 1);
      step();
    end
    IMEM_GNT = 1;
    @(negedge CLK);
    check("stall_grant_addr", IMEM_ADDR, 32'h8);
    step();
    @(negedge CLK);
    check("stall_next_addr", IMEM_ADDR, 32'hC);
    lat = 3;
    do_reset();
    repeat (4) step();
    IMEM_GNT = 0;
    REDIRECT = 1;
    REDIRECT_PC = 32'h100;
    step();
    REDIRECT = 0;
    IMEM_GNT = 1;
    @(negedge CLK);
    check("redir_addr", IMEM_ADDR, 32'h100);
    check("redir_flushed", INSTR_VALID, 0);
    for (int i = 0; i < 20 && !INSTR_VALID; i++) @(negedge CLK);
    check("redir_first_pc", INSTR_PC, 32'h100);
    check("redir_first_instr", INSTR, md(32'h100));
    lat = 1;
    do_reset();
    step();
    step();
    REDIRECT = 1;
    REDIRECT_PC = 32'h203;
    step();
    REDIRECT = 0;
    @(negedge CLK);
    check("misalign_addr", IMEM_ADDR, 32'h200);
    check("misalign_valid_t1", INSTR_VALID, 0);
    step();
    @(negedge CLK);
    check("misalign_valid_t2", INSTR_VALID, 0);
    step();
    @(negedge CLK);
    check("misalign_valid_t3", INSTR_VALID, 1);
    check("misalign_pc", INSTR_PC, 32'h200);
    check("misalign_instr", INSTR, md(32'h200));
    step();
    REDIRECT = 1;
    REDIRECT_PC = 32'hFFFF_FFFC;
    step();
    REDIRECT = 0;
    @(negedge CLK);
    check("wrap_top_addr", IMEM_ADDR, 32'hFFFF_FFFC);
    step();
    @(negedge CLK);
    check("wrap_zero_addr", IMEM_ADDR, 32'h0);
    repeat (4) step();
    INSTR_READY = 0;
    do_reset();
    repeat (8) step();
    @(negedge CLK);
    check("full_req", IMEM_REQ, 0);
    check("full_valid", INSTR_VALID, 1);
    step();
    #2;
    RESET = 1;
    #1;
    check("async_req", IMEM_REQ, 0);
    check("async_valid", INSTR_VALID, 0);
    INSTR_READY = 1;
    do_reset();
    @(negedge CLK);
    check("post_rst_addr", IMEM_ADDR, 32'h0);
    check("post_rst_req", IMEM_REQ, 1);
    check("post_rst_valid0", INSTR_VALID, 0);
    step();
    @(negedge CLK);
    check("post_rst_valid1", INSTR_VALID, 0);
    step();
    @(negedge CLK);
    check("post_rst_pc", INSTR_PC, 32'h0);
    repeat (4) step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
